// File: rtl/image_loader_if.sv
// Host byte stream (valid/ready) plus RAM port-A write bus shared by the image loader.
// master = host/RAM side, slave = loader side.
interface image_loader_if #(
    parameter int ADDR_W = 17
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address_a;
    logic [31:0]       data_a;
    logic              wren_a;
    logic [3:0]        byteena_a;

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  address_a, data_a, wren_a, byteena_a
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output address_a, data_a, wren_a, byteena_a
    );
endinterface

// File: rtl/image_loader.sv
// Frame-buffer write stage: parses a width/height header, then packs 8-bit pixels four per word
// into RAM port A. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state  | meaning
// HDR_W0 | expect width[7:0]
// HDR_W1 | expect width[15:8]
// HDR_H0 | expect height[7:0]
// HDR_H1 | expect height[15:8], then validate
// WR_W   | writing width to word 0
// WR_H   | writing height to word 1
// PIXELS | accepting pixels, writing each full group
// FLUSH  | last pixel word on the bus
// CHK    | expect checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | image written, wait for start
// ERROR  | load aborted, wait for start
module image_loader #(
    parameter int ADDR_W       = 17,
    parameter int BASE_ADDRESS = 4,
    parameter int MAX_DIM      = 640
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    image_loader_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [3:0] {
        HDR_W0, HDR_W1, HDR_H0, HDR_H1, WR_W, WR_H, PIXELS, FLUSH,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE, ERROR
    } state_t;

    state_t            state;
    logic [15:0]       width;
    logic [15:0]       height;
    logic [19:0]       total;
    logic [19:0]       pix_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       pack_buf;
    logic [31:0]       word_next;
    logic [3:0]        lane_en;
    logic [1:0]        lane;
    logic [15:0]       height_in;
    logic              accept;
    logic              last_pix;
    logic              hdr_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = bus.in_valid && bus.in_ready;
    assign lane      = pix_cnt[1:0];
    assign word_next = pack_buf | ({24'h0, bus.in_data} << {lane, 3'b000});
    assign last_pix  = (pix_cnt + 20'd1) == total;
    assign height_in = {bus.in_data, height[7:0]};
    assign hdr_bad   = (width == 16'd0) || (height_in == 16'd0) ||
                       (width > 16'(MAX_DIM)) || (height_in > 16'(MAX_DIM));

    // Lanes filled so far including the byte being accepted; unused lanes stay disabled.
    always_comb begin
        lane_en = 4'b1111;
        case (lane)
            2'd0:    lane_en = 4'b0001;
            2'd1:    lane_en = 4'b0011;
            2'd2:    lane_en = 4'b0111;
            default: lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HDR_W0;
            bus.in_ready  <= 1'b1;
            bus.wren_a    <= 1'b0;
            bus.address_a <= '0;
            bus.data_a    <= '0;
            bus.byteena_a <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            width         <= '0;
            height        <= '0;
            total         <= '0;
            pix_cnt       <= '0;
            word_idx      <= '0;
            pack_buf      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            bus.wren_a <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (accept) csum <= csum ^ bus.in_data;
`endif
            unique case (state)
                HDR_W0: if (accept) begin
                    width[7:0] <= bus.in_data;
                    busy       <= 1'b1;
                    state      <= HDR_W1;
                end
                HDR_W1: if (accept) begin
                    width[15:8] <= bus.in_data;
                    state       <= HDR_H0;
                end
                HDR_H0: if (accept) begin
                    height[7:0] <= bus.in_data;
                    state       <= HDR_H1;
                end
                HDR_H1: if (accept) begin
                    height       <= height_in;
                    bus.in_ready <= 1'b0;
                    if (hdr_bad) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end else begin
                        bus.wren_a    <= 1'b1;
                        bus.address_a <= '0;
                        bus.data_a    <= {16'h0, width};
                        bus.byteena_a <= 4'hF;
                        state         <= WR_W;
                    end
                end
                WR_W: begin
                    bus.wren_a    <= 1'b1;
                    bus.address_a <= ADDR_W'(1);
                    bus.data_a    <= {16'h0, height};
                    bus.byteena_a <= 4'hF;
                    state         <= WR_H;
                end
                WR_H: begin
                    total        <= 20'(width[9:0]) * 20'(height[9:0]);
                    pix_cnt      <= '0;
                    word_idx     <= '0;
                    pack_buf     <= '0;
                    bus.in_ready <= 1'b1;
                    state        <= PIXELS;
                end
                PIXELS: if (accept) begin
                    pix_cnt <= pix_cnt + 20'd1;
                    if (lane == 2'd3 || last_pix) begin
                        bus.wren_a    <= 1'b1;
                        bus.address_a <= ADDR_W'(BASE_ADDRESS) + word_idx;
                        bus.data_a    <= word_next;
                        bus.byteena_a <= lane_en;
                        word_idx      <= word_idx + ADDR_W'(1);
                        pack_buf      <= '0;
                    end else begin
                        pack_buf <= word_next;
                    end
                    if (last_pix) begin
                        bus.in_ready <= 1'b0;
                        state        <= FLUSH;
                    end
                end
                FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
                    bus.in_ready <= 1'b1;
                    state        <= CHK;
`else
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (accept) begin
                    error        <= (bus.in_data != csum);
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    bus.in_ready <= 1'b0;
                    state        <= DONE;
                end
`endif
                DONE, ERROR: if (start) begin
                    done         <= 1'b0;
                    error        <= 1'b0;
                    bus.in_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum         <= '0;
`endif
                    state        <= HDR_W0;
                end
                default: state <= HDR_W0;
            endcase
        end
    end
endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: directed header/packing cases plus randomized images
// compared against a word-level model of the frame-buffer layout.
module tb_image_loader;
    localparam int ADDR_W = 17;
    localparam int BASE   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, error;

    int vectors = 0;
    int miscompares = 0;
    int hdr_ready_bad = 0;
    logic exp_err;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [3:0]        wr_be[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [3:0]        exp_be[$];
    logic [7:0]        pix_q[$];

    image_loader_if #(.ADDR_W(ADDR_W)) bus();

    image_loader #(.ADDR_W(ADDR_W), .BASE_ADDRESS(BASE), .MAX_DIM(640)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wren_a) begin
            wr_addr.push_back(bus.address_a);
            wr_data.push_back(bus.data_a);
            wr_be.push_back(bus.byteena_a);
            if (bus.in_ready && bus.address_a < ADDR_W'(2)) hdr_ready_bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_be.delete();
        hdr_ready_bad = 0;
    endtask

    // Frame-buffer image the load should leave behind, in write order.
    function automatic void build_expected(input int w, input int h);
        int total, nwords;
        logic [31:0] d;
        logic [3:0] be;
        total  = w * h;
        nwords = (total + 3) / 4;
        exp_addr.delete(); exp_data.delete(); exp_be.delete();
        exp_addr.push_back(ADDR_W'(0)); exp_data.push_back(32'(w)); exp_be.push_back(4'hF);
        exp_addr.push_back(ADDR_W'(1)); exp_data.push_back(32'(h)); exp_be.push_back(4'hF);
        for (int k = 0; k < nwords; k++) begin
            d = '0; be = '0;
            for (int ln = 0; ln < 4; ln++) begin
                if (4 * k + ln < total) begin
                    d[8*ln +: 8] = pix_q[4*k+ln];
                    be[ln] = 1'b1;
                end
            end
            exp_addr.push_back(ADDR_W'(BASE + k)); exp_data.push_back(d); exp_be.push_back(be);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); bus.in_valid = 1'b0;
        end
        @(negedge clk); bus.in_valid = 1'b1; bus.in_data = b;
        n = 0;
        while (!bus.in_ready && n < 64) begin
            @(negedge clk); n++;
        end
        if (!bus.in_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk);
    endtask

    // mode 0: continuous, 1: valid every other cycle with a 3-cycle gap and a stray start, 2: random gaps
    task automatic drive_load(input int w, input int h, input int mode, input logic bad_csum);
        logic [7:0] bytes[$];
        logic [7:0] x;
        int gap, n;
        bytes = {};
        bytes.push_back(w[7:0]); bytes.push_back(w[15:8]);
        bytes.push_back(h[7:0]); bytes.push_back(h[15:8]);
        foreach (pix_q[i]) bytes.push_back(pix_q[i]);
        x = '0;
        foreach (bytes[i]) x = x ^ bytes[i];
        exp_err = bad_csum;
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(bad_csum ? (x ^ 8'h03) : x);
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < bytes.size(); i++) begin
            if (mode == 0)      gap = 0;
            else if (mode == 1) gap = (i == 7) ? 3 : 1;
            else                gap = int'($urandom_range(0, 2));
            if (mode == 1 && i == 6) begin
                @(negedge clk); bus.in_valid = 1'b0; start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            send_byte(bytes[i], gap);
        end
        @(negedge clk); bus.in_valid = 1'b0;
        n = 0;
        while (!(done || error) && n < 64) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (!(done || error)) begin
            miscompares++;
            $display("FAIL finish_timeout: done=%b error=%b, required completion", done, error);
        end
    endtask

    task automatic rearm();
        if (done || error) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.wren_a, busy, done, error, bus.byteena_a} !== 9'b1_0_000_0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required %b",
                     {bus.in_ready, bus.wren_a, busy, done, error, bus.byteena_a}, 9'b1_0_000_0000);
        end
        vectors++;
        if ({bus.address_a, bus.data_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h data=%h, required 0/0", bus.address_a, bus.data_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_4x1();
        rearm(); clear_log();
        pix_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        drive_load(4, 1, 0, 1'b0);
        @(negedge clk);
        vectors++;
        if ({done, error, busy, bus.in_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL 4x1_status: done/err/busy/rdy=%b, required 1000", {done, error, busy, bus.in_ready});
        end
        vectors++;
        if (wr_addr.size() !== 3) begin
            miscompares++;
            $display("FAIL 4x1_strobes: got %0d writes, required 3", wr_addr.size());
        end else begin
            vectors++;
            if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !==
                {ADDR_W'(0), 32'h4, ADDR_W'(1), 32'h1}) begin
                miscompares++;
                $display("FAIL 4x1_header: a0=%h d0=%h a1=%h d1=%h, required 0/4 1/1",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
            vectors++;
            if ({wr_addr[2], wr_data[2], wr_be[2]} !== {ADDR_W'(4), 32'hDDCCBBAA, 4'hF}) begin
                miscompares++;
                $display("FAIL 4x1_pixels: a=%h d=%h be=%h, required 4/DDCCBBAA/F",
                         wr_addr[2], wr_data[2], wr_be[2]);
            end
        end
    endtask

    task automatic test_5x1();
        rearm(); clear_log();
        pix_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drive_load(5, 1, 0, 1'b0);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL 5x1_done: got %b, required 1", done);
        end
        vectors++;
        if (wr_addr.size() !== 4) begin
            miscompares++;
            $display("FAIL 5x1_strobes: got %0d writes, required 4", wr_addr.size());
        end else begin
            vectors++;
            if ({wr_addr[2], wr_data[2], wr_be[2]} !== {ADDR_W'(4), 32'h44332211, 4'hF}) begin
                miscompares++;
                $display("FAIL 5x1_word4: a=%h d=%h be=%h, required 4/44332211/F",
                         wr_addr[2], wr_data[2], wr_be[2]);
            end
            vectors++;
            if ({wr_addr[3], wr_data[3], wr_be[3]} !== {ADDR_W'(5), 32'h00000055, 4'b0001}) begin
                miscompares++;
                $display("FAIL 5x1_flush: a=%h d=%h be=%b, required 5/00000055/0001",
                         wr_addr[3], wr_data[3], wr_be[3]);
            end
        end
    endtask

    task automatic compare_log(input string name);
        vectors++;
        if (wr_addr.size() !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, wr_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                vectors++;
                if ({wr_addr[i], wr_data[i], wr_be[i]} !== {exp_addr[i], exp_data[i], exp_be[i]}) begin
                    miscompares++;
                    $display("FAIL %s_write%0d: got %h/%h/%b, required %h/%h/%b", name, i,
                             wr_addr[i], wr_data[i], wr_be[i], exp_addr[i], exp_data[i], exp_be[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        rearm(); clear_log();
        pix_q = {};
        for (int i = 0; i < 8; i++) pix_q.push_back(8'($urandom));
        build_expected(4, 2);
        drive_load(4, 2, 1, 1'b0);
        compare_log("gaps");
        vectors++;
        if (hdr_ready_bad !== 0) begin
            miscompares++;
            $display("FAIL gaps_ready_hdr: in_ready high on %0d header writes, required 0", hdr_ready_bad);
        end
        vectors++;
        if ({done, error} !== 2'b10) begin
            miscompares++;
            $display("FAIL gaps_status: done/err=%b, required 10", {done, error});
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdr[2][4];
        hdr[0] = '{8'h00, 8'h00, 8'h02, 8'h00};
        hdr[1] = '{8'h01, 8'h00, 8'h81, 8'h02};
        for (int t = 0; t < 2; t++) begin
            rearm(); clear_log();
            for (int i = 0; i < 4; i++) send_byte(hdr[t][i], 0);
            @(negedge clk); bus.in_valid = 1'b0;
            vectors++;
            if ({error, done, busy, bus.in_ready} !== 4'b1000) begin
                miscompares++;
                $display("FAIL badhdr%0d_status: err/done/busy/rdy=%b, required 1000", t,
                         {error, done, busy, bus.in_ready});
            end
            repeat (5) @(negedge clk);
            vectors++;
            if (wr_addr.size() !== 0) begin
                miscompares++;
                $display("FAIL badhdr%0d_writes: got %0d, required 0", t, wr_addr.size());
            end
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        vectors++;
        if ({error, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL badhdr_clear: err/rdy=%b, required 01", {error, bus.in_ready});
        end
        clear_log();
        pix_q = {8'h5A};
        build_expected(1, 1);
        drive_load(1, 1, 0, 1'b0);
        compare_log("after_err");
        vectors++;
        if ({done, error} !== 2'b10) begin
            miscompares++;
            $display("FAIL after_err_status: done/err=%b, required 10", {done, error});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] hdr[4];
        rearm(); clear_log();
        hdr = '{8'hC2, 8'h01, 8'hC2, 8'h01};
        for (int i = 0; i < 4; i++) send_byte(hdr[i], 0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        @(negedge clk); bus.in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_busy: got %b, required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.wren_a, busy, done, error, bus.byteena_a, bus.address_a, bus.data_a} !==
            {9'b1_0_000_0000, ADDR_W'(0), 32'h0}) begin
            miscompares++;
            $display("FAIL midrst_outputs: flags=%b addr=%h data=%h, required 100000000/0/0",
                     {bus.in_ready, bus.wren_a, busy, done, error, bus.byteena_a}, bus.address_a, bus.data_a);
        end
        rst = 1'b0;
        clear_log();
        pix_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build_expected(4, 1);
        drive_load(4, 1, 0, 1'b0);
        compare_log("midrst_reload");
    endtask

    task automatic test_random();
        int w, h;
        for (int it = 0; it < 5; it++) begin
            w = (it == 0) ? 640 : int'($urandom_range(1, 9));
            h = (it == 0) ? 1   : int'($urandom_range(1, 4));
            rearm(); clear_log();
            pix_q = {};
            for (int i = 0; i < w * h; i++) pix_q.push_back(8'($urandom));
            build_expected(w, h);
            drive_load(w, h, 2, 1'b0);
            compare_log($sformatf("rand%0d", it));
            vectors++;
            if ({done, error, busy} !== 3'b100) begin
                miscompares++;
                $display("FAIL rand%0d_status: done/err/busy=%b, required 100", it, {done, error, busy});
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int t = 0; t < 2; t++) begin
            rearm(); clear_log();
            pix_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
            build_expected(4, 1);
            drive_load(4, 1, 0, t == 1);
            compare_log($sformatf("csum%0d", t));
            vectors++;
            if ({done, error} !== {1'b1, exp_err}) begin
                miscompares++;
                $display("FAIL csum%0d_status: done/err=%b, required %b", t, {done, error}, {1'b1, exp_err});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_4x1();
        test_5x1();
        test_gaps();
        test_bad_header();
        test_reset_mid();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
